// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipelined datapath and its sequencing controller.
// The datapath drives hazard status (master); the controller returns latch and PC control (slave).
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             ihit;
    logic             dhit;
    logic             mem_dREN;
    logic             mem_dWEN;
    logic             ex_memRd;
    logic [4:0]       ex_regDst;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             ex_pcsrc_taken;
    logic             id_halt;
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             memwb_flush;
    logic             halt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output ihit, dhit, mem_dREN, mem_dWEN, ex_memRd, ex_regDst, id_rs, id_rt,
               ex_pcsrc_taken, id_halt,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               halt, stall_cnt, flush_cnt
    );

    modport slave (
        input  ihit, dhit, mem_dREN, mem_dWEN, ex_memRd, ex_regDst, id_rs, id_rt,
               ex_pcsrc_taken, id_halt,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               halt, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Per-cycle advance/hold/bubble decisions for the 5-stage pipeline: load-use stalls,
// taken-branch squashes, cache wait states and halt draining, plus stall/flush counters.
module pipeline_hazard_ctrl #(
    parameter int DRAIN_DEPTH = 3,
    parameter int CNT_W       = 32
) (
    input logic                  CLK,
    input logic                  RST,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam int DW = $clog2(DRAIN_DEPTH + 1);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t                     state_reg;
    logic [DW-1:0]              drain_reg;
    logic                       halt_reg;
    logic [1:0][CNT_W-1:0]      cnt_reg;
    logic [1:0][CNT_W-1:0]      cnt_next;
    logic [1:0]                 cnt_inc;

    logic memwait, loaduse, branch_go, active;
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush, exmem_flush, memwb_flush;

    assign memwait   = (hz.mem_dREN | hz.mem_dWEN) & ~hz.dhit;
    assign loaduse   = hz.ex_memRd && (hz.ex_regDst != 5'd0) &&
                       ((hz.ex_regDst == hz.id_rs) || (hz.ex_regDst == hz.id_rt));
    // A branch resolved under a data-cache wait is deferred until the access completes.
    assign branch_go = hz.ex_pcsrc_taken & ~memwait;
    assign active    = ~RST && (state_reg != HALTED);

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        if (RST) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
            {ifid_flush, idex_flush, exmem_flush, memwb_flush} = '1;
        end else if (state_reg == HALTED) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
        end else begin
            if (memwait) begin
                {pc_en, ifid_en, idex_en, exmem_en} = '0;
                memwb_flush = 1'b1;
            end else if (branch_go) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (loaduse) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end else if (!hz.ihit && state_reg == RUN) begin
                pc_en      = 1'b0;
                ifid_flush = 1'b1;
            end
            // While draining, nothing behind the halt may enter; a taken branch reopens fetch.
            if (state_reg == DRAIN && !branch_go) begin
                pc_en      = 1'b0;
                ifid_flush = 1'b1;
            end
        end
    end

    assign cnt_inc = {active & branch_go, active & ~pc_en};

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        assign cnt_next[gi] = (cnt_inc[gi] && cnt_reg[gi] != {CNT_W{1'b1}}) ?
                              cnt_reg[gi] + 1'b1 : cnt_reg[gi];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= RUN;
            drain_reg <= '0;
            halt_reg  <= 1'b0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (!memwait && !hz.ex_pcsrc_taken && hz.id_halt) begin
                        state_reg <= DRAIN;
                        drain_reg <= DW'(DRAIN_DEPTH);
                    end
                end
                DRAIN: begin
                    if (!memwait) begin
                        if (hz.ex_pcsrc_taken) begin
                            state_reg <= RUN;
                            drain_reg <= '0;
                        end else if (drain_reg == DW'(1)) begin
                            state_reg <= HALTED;
                            drain_reg <= '0;
                            halt_reg  <= 1'b1;
                        end else begin
                            drain_reg <= drain_reg - 1'b1;
                        end
                    end
                end
                HALTED: state_reg <= HALTED;
                default: state_reg <= RUN;
            endcase
        end
    end

    assign hz.pc_en       = pc_en;
    assign hz.ifid_en     = ifid_en;
    assign hz.idex_en     = idex_en;
    assign hz.exmem_en    = exmem_en;
    assign hz.memwb_en    = memwb_en;
    assign hz.ifid_flush  = ifid_flush;
    assign hz.idex_flush  = idex_flush;
    assign hz.exmem_flush = exmem_flush;
    assign hz.memwb_flush = memwb_flush;
    assign hz.halt        = halt_reg;
    assign hz.stall_cnt   = cnt_reg[0];
    assign hz.flush_cnt   = cnt_reg[1];
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed checks of the hazard controller; latch behaviour is compared as the
// effective action per latch (hold/load/bubble) together with pc_en.
module tb_pipeline_hazard_ctrl;
    localparam int CW = 4;
    localparam logic [1:0] H = 2'd0, L = 2'd1, B = 2'd2;
    localparam logic [8:0] P_NORM   = {1'b1, L, L, L, L};
    localparam logic [8:0] P_RST    = {1'b0, B, B, B, B};
    localparam logic [8:0] P_FROZEN = {1'b0, H, H, H, H};
    localparam logic [8:0] P_MEMW   = {1'b0, H, H, H, B};
    localparam logic [8:0] P_TAKEN  = {1'b1, B, B, L, L};
    localparam logic [8:0] P_LU     = {1'b0, H, B, L, L};
    localparam logic [8:0] P_IMISS  = {1'b0, B, L, L, L};
    localparam logic [8:0] P_DRAIN  = {1'b0, B, L, L, L};
    localparam logic [8:0] P_DRMW   = {1'b0, B, H, H, B};

    logic CLK = 1'b0;
    logic RST;
    int   total = 0;
    int   bad   = 0;

    pipeline_hazard_ctrl_if #(.CNT_W(CW)) hz ();
    pipeline_hazard_ctrl #(.DRAIN_DEPTH(3), .CNT_W(CW)) dut (.CLK(CLK), .RST(RST), .hz(hz));

    always #5 CLK = ~CLK;

    function automatic logic [1:0] lat(input logic en, input logic fl);
        return fl ? B : (en ? L : H);
    endfunction

    function automatic logic [8:0] act();
        return {hz.pc_en, lat(hz.ifid_en, hz.ifid_flush), lat(hz.idex_en, hz.idex_flush),
                lat(hz.exmem_en, hz.exmem_flush), lat(hz.memwb_en, hz.memwb_flush)};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        hz.ihit = 1'b1; hz.dhit = 1'b1; hz.mem_dREN = 1'b0; hz.mem_dWEN = 1'b0;
        hz.ex_memRd = 1'b0; hz.ex_regDst = 5'd0; hz.id_rs = 5'd0; hz.id_rt = 5'd0;
        hz.ex_pcsrc_taken = 1'b0; hz.id_halt = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        settle();
    endtask

    task automatic test_reset();
        idle();
        hz.ex_memRd = 1'b1; hz.ex_regDst = 5'd3; hz.id_rs = 5'd3;
        RST = 1'b1;
        settle();
        total++;
        if (act() !== P_RST) begin bad++; $display("FAIL reset_outputs: got %b want %b", act(), P_RST); end
        tick();
        RST = 1'b0;
        idle();
        settle();
        total++;
        if ({hz.halt, hz.stall_cnt, hz.flush_cnt} !== 9'd0) begin
            bad++; $display("FAIL reset_state: halt=%b stall=%0d flush=%0d want 0/0/0", hz.halt, hz.stall_cnt, hz.flush_cnt);
        end
        total++;
        if (act() !== P_NORM) begin bad++; $display("FAIL reset_normal: got %b want %b", act(), P_NORM); end
        $display("reset: outputs=%b halt=%b", act(), hz.halt);
    endtask

    task automatic test_load_use();
        do_reset();
        hz.ex_memRd = 1'b1; hz.ex_regDst = 5'd2; hz.id_rs = 5'd2;
        settle();
        total++;
        if (act() !== P_LU) begin bad++; $display("FAIL loaduse_rs: got %b want %b", act(), P_LU); end
        tick();
        idle();
        settle();
        total++;
        if (act() !== P_NORM || hz.stall_cnt !== 4'd1) begin
            bad++; $display("FAIL loaduse_after: got %b stall=%0d want %b stall=1", act(), hz.stall_cnt, P_NORM);
        end
        hz.ex_memRd = 1'b1; hz.ex_regDst = 5'd7; hz.id_rs = 5'd1; hz.id_rt = 5'd7;
        settle();
        total++;
        if (act() !== P_LU) begin bad++; $display("FAIL loaduse_rt: got %b want %b", act(), P_LU); end
        tick();
        hz.ex_regDst = 5'd0; hz.id_rs = 5'd0; hz.id_rt = 5'd0;
        settle();
        total++;
        if (act() !== P_NORM) begin bad++; $display("FAIL loaduse_r0: got %b want %b", act(), P_NORM); end
        tick();
        total++;
        if (hz.stall_cnt !== 4'd2) begin bad++; $display("FAIL loaduse_cnt: got %0d want 2", hz.stall_cnt); end
        $display("load_use: stall_cnt=%0d", hz.stall_cnt);
    endtask

    task automatic test_dcache_miss();
        do_reset();
        hz.mem_dREN = 1'b1; hz.dhit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            total++;
            if (act() !== P_MEMW) begin bad++; $display("FAIL dmiss_cycle%0d: got %b want %b", i, act(), P_MEMW); end
            tick();
        end
        hz.dhit = 1'b1;
        settle();
        total++;
        if (act() !== P_NORM || hz.stall_cnt !== 4'd4) begin
            bad++; $display("FAIL dmiss_release: got %b stall=%0d want %b stall=4", act(), hz.stall_cnt, P_NORM);
        end
        hz.mem_dREN = 1'b0; hz.mem_dWEN = 1'b1; hz.dhit = 1'b0;
        settle();
        total++;
        if (act() !== P_MEMW) begin bad++; $display("FAIL dmiss_write: got %b want %b", act(), P_MEMW); end
        tick();
        idle();
        $display("dcache_miss: stall_cnt=%0d", hz.stall_cnt);
    endtask

    task automatic test_ihit_miss();
        do_reset();
        hz.ihit = 1'b0;
        settle();
        total++;
        if (act() !== P_IMISS) begin bad++; $display("FAIL imiss_out: got %b want %b", act(), P_IMISS); end
        tick();
        total++;
        if (hz.stall_cnt !== 4'd1) begin bad++; $display("FAIL imiss_cnt: got %0d want 1", hz.stall_cnt); end
        idle();
        $display("ihit_miss: stall_cnt=%0d", hz.stall_cnt);
    endtask

    task automatic test_branch();
        do_reset();
        hz.ex_pcsrc_taken = 1'b1; hz.ex_memRd = 1'b1; hz.ex_regDst = 5'd4; hz.id_rs = 5'd4;
        settle();
        total++;
        if (act() !== P_TAKEN) begin bad++; $display("FAIL branch_lu_out: got %b want %b", act(), P_TAKEN); end
        tick();
        idle();
        settle();
        total++;
        if (hz.flush_cnt !== 4'd1 || hz.stall_cnt !== 4'd0) begin
            bad++; $display("FAIL branch_lu_cnt: flush=%0d stall=%0d want 1/0", hz.flush_cnt, hz.stall_cnt);
        end
        hz.ex_pcsrc_taken = 1'b1; hz.mem_dREN = 1'b1; hz.dhit = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle();
            total++;
            if (act() !== P_MEMW) begin bad++; $display("FAIL branch_mw%0d: got %b want %b", i, act(), P_MEMW); end
            tick();
        end
        hz.dhit = 1'b1;
        settle();
        total++;
        if (act() !== P_TAKEN) begin bad++; $display("FAIL branch_mw_go: got %b want %b", act(), P_TAKEN); end
        tick();
        idle();
        settle();
        total++;
        if (hz.flush_cnt !== 4'd2 || hz.stall_cnt !== 4'd2) begin
            bad++; $display("FAIL branch_mw_cnt: flush=%0d stall=%0d want 2/2", hz.flush_cnt, hz.stall_cnt);
        end
        $display("branch: flush_cnt=%0d stall_cnt=%0d", hz.flush_cnt, hz.stall_cnt);
    endtask

    task automatic test_halt();
        do_reset();
        hz.id_halt = 1'b1;
        settle();
        total++;
        if (act() !== P_NORM) begin bad++; $display("FAIL halt_issue: got %b want %b", act(), P_NORM); end
        tick();
        idle();
        hz.ihit = 1'b0;
        for (int e = 2; e <= 4; e++) begin
            settle();
            total++;
            if (act() !== P_DRAIN || hz.halt !== 1'b0) begin
                bad++; $display("FAIL halt_drain_e%0d: got %b halt=%b want %b halt=0", e, act(), hz.halt, P_DRAIN);
            end
            tick();
        end
        total++;
        if (hz.halt !== 1'b1 || act() !== P_FROZEN) begin
            bad++; $display("FAIL halt_set: halt=%b out=%b want 1 %b", hz.halt, act(), P_FROZEN);
        end
        hz.ex_pcsrc_taken = 1'b1;
        tick();
        tick();
        total++;
        if (hz.halt !== 1'b1 || hz.stall_cnt !== 4'd3 || hz.flush_cnt !== 4'd0 || act() !== P_FROZEN) begin
            bad++; $display("FAIL halt_sticky: halt=%b stall=%0d flush=%0d out=%b want 1/3/0 %b",
                            hz.halt, hz.stall_cnt, hz.flush_cnt, act(), P_FROZEN);
        end
        idle();
        RST = 1'b1;
        settle();
        total++;
        if (act() !== P_RST) begin bad++; $display("FAIL halt_rst_out: got %b want %b", act(), P_RST); end
        tick();
        RST = 1'b0;
        settle();
        total++;
        if (hz.halt !== 1'b0 || hz.stall_cnt !== 4'd0 || act() !== P_NORM) begin
            bad++; $display("FAIL halt_rst_clear: halt=%b stall=%0d out=%b want 0/0 %b", hz.halt, hz.stall_cnt, act(), P_NORM);
        end
        $display("halt: cleared by reset, halt=%b", hz.halt);
    endtask

    task automatic test_halt_memwait();
        do_reset();
        hz.id_halt = 1'b1;
        tick();
        idle();
        tick();
        hz.mem_dREN = 1'b1; hz.dhit = 1'b0;
        settle();
        total++;
        if (act() !== P_DRMW) begin bad++; $display("FAIL hmw_out: got %b want %b", act(), P_DRMW); end
        tick();
        tick();
        idle();
        tick();
        total++;
        if (hz.halt !== 1'b0) begin bad++; $display("FAIL hmw_early: halt=%b want 0 after 5 edges", hz.halt); end
        tick();
        total++;
        if (hz.halt !== 1'b1 || hz.stall_cnt !== 4'd5) begin
            bad++; $display("FAIL hmw_halt: halt=%b stall=%0d want 1/5 after 6 edges", hz.halt, hz.stall_cnt);
        end
        $display("halt_memwait: halt=%b stall_cnt=%0d", hz.halt, hz.stall_cnt);
    endtask

    task automatic test_halt_branch();
        do_reset();
        hz.id_halt = 1'b1;
        tick();
        idle();
        hz.ex_pcsrc_taken = 1'b1;
        settle();
        total++;
        if (act() !== P_TAKEN) begin bad++; $display("FAIL hbr_out: got %b want %b", act(), P_TAKEN); end
        tick();
        idle();
        settle();
        total++;
        if (act() !== P_NORM) begin bad++; $display("FAIL hbr_run: got %b want %b", act(), P_NORM); end
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (hz.halt !== 1'b0 || hz.flush_cnt !== 4'd1 || hz.pc_en !== 1'b1) begin
            bad++; $display("FAIL hbr_nohalt: halt=%b flush=%0d pc_en=%b want 0/1/1", hz.halt, hz.flush_cnt, hz.pc_en);
        end
        hz.id_halt = 1'b1;
        tick();
        idle();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        settle();
        total++;
        if (act() !== P_NORM || hz.flush_cnt !== 4'd0) begin
            bad++; $display("FAIL hbr_rst_drain: out=%b flush=%0d want %b/0", act(), hz.flush_cnt, P_NORM);
        end
        $display("halt_branch: halt=%b", hz.halt);
    endtask

    task automatic test_saturation();
        do_reset();
        hz.ihit = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        idle();
        hz.ex_pcsrc_taken = 1'b1;
        for (int i = 0; i < 18; i++) tick();
        idle();
        settle();
        total++;
        if (hz.stall_cnt !== 4'd15 || hz.flush_cnt !== 4'd15) begin
            bad++; $display("FAIL saturate: stall=%0d flush=%0d want 15/15", hz.stall_cnt, hz.flush_cnt);
        end
        $display("saturation: stall_cnt=%0d flush_cnt=%0d", hz.stall_cnt, hz.flush_cnt);
    endtask

    initial begin
        idle();
        RST = 1'b1;
        tick();
        tick();
        test_reset();
        test_load_use();
        test_dcache_miss();
        test_ihit_miss();
        test_branch();
        test_halt();
        test_halt_memwait();
        test_halt_branch();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
